// File: rtl/timestamp_word_decoder_pkg.sv
// timestamp_word_decoder_pkg: word types, register map and FSM states for the timestamp word decoder
package timestamp_word_decoder_pkg;
  localparam logic [3:0] TYPE_LO  = 4'h1;
  localparam logic [3:0] TYPE_MID = 4'h2;
  localparam logic [3:0] TYPE_TOP = 4'h3;
  localparam logic [7:0] VERSION  = 8'd1;
  localparam int ADDR_VERSION = 0;
  localparam int ADDR_CONF    = 2;
  localparam int ADDR_SEQ     = 3;
  localparam int ADDR_FOREIGN = 4;
  localparam int ADDR_MONO    = 5;
  localparam int ADDR_DEC_LO  = 6;
  localparam int ADDR_DEC_HI  = 7;
  typedef enum logic [1:0] {WAIT_LO, WAIT_HI, WAIT_TOP, OUT} state_t;
endpackage

// File: rtl/timestamp_word_decoder_sat_cnt8.sv
// sat_cnt8: 8-bit counter that sticks at 0xFF, synchronous clear
module sat_cnt8 (
  input  logic       BUS_CLK,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);
  logic [7:0] cnt_q;
  always_ff @(posedge BUS_CLK)
    cnt_q <= clr_i ? 8'h00 : (inc_i && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/timestamp_word_decoder.sv
// timestamp_word_decoder: pops FWFT timestamp words, reassembles 64-bit timestamps, flags protocol errors
module timestamp_word_decoder
  import timestamp_word_decoder_pkg::*;
#(
  parameter int         ABUSWIDTH      = 16,
  parameter logic [3:0] IDENTIFIER     = 4'b0001,
  parameter bit         WITH_HIGH_WORD = 1'b0
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic                 FIFO_EMPTY,
  input  logic [31:0]          FIFO_DATA,
  output logic                 FIFO_READ,
  output logic [63:0]          TS_DATA,
  output logic                 TS_VALID,
  input  logic                 TS_READY,
  output logic                 ERR_PULSE,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD
);
  state_t state_q, state_d;
  logic [23:0] lo_q, lo_d, mid_q, mid_d;
  logic [15:0] top_q, top_d;
  logic [63:0] last_q;
  logic [15:0] dec_q;
  logic [7:0] rd_q, rd_d;
  logic [7:0] seq_cnt, foreign_cnt, mono_cnt;
  logic [3:0] w_id, w_type;
  logic [23:0] w_p;
  logic rst_int, conf_en_q, conf_mono_q, have_last_q, err_q;
  logic pop, foreign, seq_err, mono_err, hs;
  assign rst_int = RST | (BUS_WR & (BUS_ADD == ABUSWIDTH'(ADDR_VERSION)));
  assign {w_id, w_type, w_p} = FIFO_DATA;
  assign pop = conf_en_q & ~FIFO_EMPTY & (state_q != OUT);
  assign foreign = pop & (w_id != IDENTIFIER);
  assign hs = (state_q == OUT) & TS_READY;
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    mid_d = mid_q;
    top_d = top_q;
    seq_err = 1'b0;
    if (pop && !foreign) begin
      case (state_q)
        WAIT_LO:
          if (w_type == TYPE_LO) begin
            lo_d = w_p;
            state_d = WAIT_HI;
          end else seq_err = 1'b1;
        WAIT_HI:
          if (w_type == TYPE_MID) begin
            mid_d = w_p;
            state_d = WITH_HIGH_WORD ? WAIT_TOP : OUT;
          end else begin
            seq_err = 1'b1;
            if (w_type == TYPE_LO) lo_d = w_p;
            else state_d = WAIT_LO;
          end
        WAIT_TOP:
          if (w_type == TYPE_TOP && w_p[23:16] == 8'h00) begin
            top_d = w_p[15:0];
            state_d = OUT;
          end else begin
            seq_err = 1'b1;
            lo_d = (w_type == TYPE_LO) ? w_p : lo_q;
            state_d = (w_type == TYPE_LO) ? WAIT_HI : WAIT_LO;
          end
        default: ;
      endcase
    end
    if (hs) state_d = WAIT_LO;
  end
  // the very first timestamp after reset has nothing to be compared against
  assign mono_err = (state_d == OUT) & (state_q != OUT) & conf_mono_q & have_last_q &
                    ({top_d, mid_d, lo_d} <= last_q);
  always_comb begin
    rd_d = 8'h00;
    case (BUS_ADD)
      ABUSWIDTH'(ADDR_VERSION): rd_d = VERSION;
      ABUSWIDTH'(ADDR_CONF):    rd_d = {6'b0, conf_mono_q, conf_en_q};
      ABUSWIDTH'(ADDR_SEQ):     rd_d = seq_cnt;
      ABUSWIDTH'(ADDR_FOREIGN): rd_d = foreign_cnt;
      ABUSWIDTH'(ADDR_MONO):    rd_d = mono_cnt;
      ABUSWIDTH'(ADDR_DEC_LO):  rd_d = dec_q[7:0];
      ABUSWIDTH'(ADDR_DEC_HI):  rd_d = dec_q[15:8];
      default:                  rd_d = 8'h00;
    endcase
  end
  always_ff @(posedge BUS_CLK) begin
    if (rst_int) begin
      state_q <= WAIT_LO;
      lo_q <= '0;
      mid_q <= '0;
      top_q <= '0;
      last_q <= '0;
      have_last_q <= 1'b0;
      dec_q <= '0;
      err_q <= 1'b0;
      rd_q <= '0;
      conf_en_q <= 1'b0;
      conf_mono_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      mid_q <= mid_d;
      top_q <= top_d;
      err_q <= foreign | seq_err | mono_err;
      if (hs) begin
        last_q <= TS_DATA;
        have_last_q <= 1'b1;
        dec_q <= dec_q + 16'd1;
      end
      if (BUS_WR && BUS_ADD == ABUSWIDTH'(ADDR_CONF)) {conf_mono_q, conf_en_q} <= BUS_DATA_IN[1:0];
      if (BUS_RD) rd_q <= rd_d;
    end
  end
  sat_cnt8 u_seq_cnt (.BUS_CLK(BUS_CLK), .clr_i(rst_int), .inc_i(seq_err), .cnt_o(seq_cnt));
  sat_cnt8 u_foreign_cnt (.BUS_CLK(BUS_CLK), .clr_i(rst_int), .inc_i(foreign), .cnt_o(foreign_cnt));
  sat_cnt8 u_mono_cnt (.BUS_CLK(BUS_CLK), .clr_i(rst_int), .inc_i(mono_err), .cnt_o(mono_cnt));
  assign FIFO_READ = pop;
  assign TS_VALID = (state_q == OUT);
  assign TS_DATA = {top_q, mid_q, lo_q};
  assign ERR_PULSE = err_q;
  assign BUS_DATA_OUT = rd_q;
endmodule

// File: tb/tb_timestamp_word_decoder.sv
// tb_timestamp_word_decoder: random and directed checks of two decoder instances against a word-counting model
module tb_timestamp_word_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] bus_add = '0;
  logic [7:0] bus_din = '0;
  logic bus_wr = 1'b0, bus_rd = 1'b0;
  logic fe0 = 1'b1, fe1 = 1'b1, fr0, fr1, tv0, tv1, er0, er1;
  logic rdy0 = 1'b1, rdy1 = 1'b1;
  logic [31:0] fd0 = '0, fd1 = '0;
  logic [63:0] tsd0, tsd1;
  logic [7:0] bdo0, bdo1;
  logic [31:0] q0[$], q1[$];
  int k[2], nseq[2], nfrn[2], nmono[2], ndec[2], gen[2];
  logic [23:0] pl[2][3];
  logic [63:0] tsx[2], last[2];
  bit pend[2], hl[2], errx[2];
  bit m_en, m_mono;
  int n_chk = 0, n_fail = 0, npulse0 = 0;
  timestamp_word_decoder #(.WITH_HIGH_WORD(1'b0)) dut0 (
    .BUS_CLK(clk), .RST(rst), .FIFO_EMPTY(fe0), .FIFO_DATA(fd0), .FIFO_READ(fr0),
    .TS_DATA(tsd0), .TS_VALID(tv0), .TS_READY(rdy0), .ERR_PULSE(er0), .BUS_ADD(bus_add),
    .BUS_DATA_IN(bus_din), .BUS_DATA_OUT(bdo0), .BUS_WR(bus_wr), .BUS_RD(bus_rd));
  timestamp_word_decoder #(.WITH_HIGH_WORD(1'b1)) dut1 (
    .BUS_CLK(clk), .RST(rst), .FIFO_EMPTY(fe1), .FIFO_DATA(fd1), .FIFO_READ(fr1),
    .TS_DATA(tsd1), .TS_VALID(tv1), .TS_READY(rdy1), .ERR_PULSE(er1), .BUS_ADD(bus_add),
    .BUS_DATA_IN(bus_din), .BUS_DATA_OUT(bdo1), .BUS_WR(bus_wr), .BUS_RD(bus_rd));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction
  function automatic logic [7:0] sat(int n);
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction
  function automatic logic [7:0] exp_reg(int i, logic [15:0] a);
    case (a)
      16'd0: return 8'h01;
      16'd2: return {6'b0, m_mono, m_en};
      16'd3: return sat(nseq[i]);
      16'd4: return sat(nfrn[i]);
      16'd5: return sat(nmono[i]);
      16'd6: return 8'(ndec[i]);
      16'd7: return 8'(ndec[i] >> 8);
      default: return 8'h00;
    endcase
  endfunction
  task automatic mreset(int i);
    k[i] = 0; pend[i] = 0; hl[i] = 0; last[i] = '0; errx[i] = 0;
    nseq[i] = 0; nfrn[i] = 0; nmono[i] = 0; ndec[i] = 0;
  endtask
  // a timestamp is the next word types 1,2(,3) in order; a stray type 1 restarts collection
  task automatic consume(int i, logic [31:0] w);
    logic [3:0] t;
    logic [23:0] p;
    int need;
    t = w[27:24];
    p = w[23:0];
    need = (i == 1) ? 3 : 2;
    if (w[31:28] != 4'h1) begin
      nfrn[i]++;
      errx[i] = 1;
    end else if (t == 4'(k[i] + 1) && !(t == 4'h3 && p[23:16] != 8'h00)) begin
      pl[i][k[i]] = p;
      k[i]++;
      if (k[i] == need) begin
        k[i] = 0;
        pend[i] = 1;
        tsx[i] = {(i == 1) ? pl[i][2][15:0] : 16'h0, pl[i][1], pl[i][0]};
        if (m_mono && hl[i] && tsx[i] <= last[i]) begin
          nmono[i]++;
          errx[i] = 1;
        end
      end
    end else begin
      nseq[i]++;
      errx[i] = 1;
      k[i] = (t == 4'h1) ? 1 : 0;
      if (t == 4'h1) pl[i][0] = p;
    end
  endtask
  task automatic refresh();
    fe0 = (q0.size() == 0);
    fd0 = fe0 ? 32'h0 : q0[0];
    fe1 = (q1.size() == 0);
    fd1 = fe1 ? 32'h0 : q1[0];
  endtask
  task automatic push(int i, logic [31:0] w);
    if (i == 0) q0.push_back(w);
    else q1.push_back(w);
    refresh();
  endtask
  task automatic tick();
    bit rd[2], hs[2];
    bit sr, dord;
    logic [7:0] rexp[2];
    logic [31:0] w;
    #1;
    rd[0] = fr0;
    rd[1] = fr1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("fifo_read%0d", i), 64'(rd[i]), 64'(m_en && qsize(i) > 0 && !pend[i]));
      hs[i] = pend[i] && ((i == 0) ? rdy0 : rdy1);
      rexp[i] = exp_reg(i, bus_add);
    end
    sr = rst || (bus_wr && bus_add == 16'd0);
    dord = bus_rd;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      w = '0;
      if (rd[i] && qsize(i) > 0) w = (i == 0) ? q0.pop_front() : q1.pop_front();
      if (sr) begin
        mreset(i);
        rexp[i] = 8'h00;
      end else begin
        errx[i] = 0;
        if (hs[i]) begin
          ndec[i] = (ndec[i] + 1) & 32'hFFFF;
          last[i] = tsx[i];
          hl[i] = 1;
          pend[i] = 0;
        end
        if (rd[i]) consume(i, w);
      end
    end
    if (sr) begin
      m_en = 0;
      m_mono = 0;
    end else if (bus_wr && bus_add == 16'd2) begin
      m_en = bus_din[0];
      m_mono = bus_din[1];
    end
    refresh();
    chk("ts_valid0", 64'(tv0), 64'(pend[0]));
    chk("ts_valid1", 64'(tv1), 64'(pend[1]));
    if (pend[0]) chk("ts_data0", tsd0, tsx[0]);
    if (pend[1]) chk("ts_data1", tsd1, tsx[1]);
    chk("err_pulse0", 64'(er0), 64'(errx[0]));
    chk("err_pulse1", 64'(er1), 64'(errx[1]));
    if (dord) begin
      chk("bus_data_out0", 64'(bdo0), 64'(rexp[0]));
      chk("bus_data_out1", 64'(bdo1), 64'(rexp[1]));
    end
    npulse0 += int'(er0);
  endtask
  task automatic bus_read(logic [15:0] a);
    bus_add = a;
    bus_rd = 1;
    tick();
    bus_rd = 0;
  endtask
  task automatic bus_write(logic [15:0] a, logic [7:0] d);
    bus_add = a;
    bus_din = d;
    bus_wr = 1;
    tick();
    bus_wr = 0;
  endtask
  task automatic wait_valid(int i, int n);
    bit seen = 0;
    for (int c = 0; c < n && !seen; c++) begin
      if ((i == 0) ? tv0 : tv1) seen = 1;
      else tick();
    end
    if (!seen && ((i == 0) ? tv0 : tv1)) seen = 1;
    if (!seen) chk($sformatf("wait_valid%0d_timeout", i), 64'(0), 64'(1));
  endtask
  function automatic logic [31:0] rnd_word(int i);
    logic [3:0] id, t;
    logic [23:0] p;
    id = ($urandom % 16 == 0) ? 4'($urandom) : 4'h1;
    t = ($urandom % 10 == 0) ? 4'($urandom % 5) : 4'(gen[i] + 1);
    gen[i] = (gen[i] + 1) % ((i == 1) ? 3 : 2);
    p = 24'($urandom);
    if (t == 4'h3 && $urandom % 8 != 0) p[23:16] = 8'h00;
    return {id, t, p};
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int pulses;
    mreset(0);
    mreset(1);
    m_en = 0;
    m_mono = 0;
    gen[0] = 0;
    gen[1] = 0;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset_ts_data0", tsd0, 64'h0);
    for (int a = 0; a < 10; a++) bus_read(16'(a));
    bus_read(16'd0);
    chk("version", 64'(bdo0), 64'h01);
    bus_write(16'd2, 8'h01);
    push(0, 32'h11ABCDEF);
    push(0, 32'h12123456);
    wait_valid(0, 10);
    chk("t1_ts", tsd0, 64'h0000_1234_56AB_CDEF);
    tick();
    bus_read(16'd6);
    chk("t1_decoded", 64'(bdo0), 64'h01);
    rdy0 = 0;
    push(0, 32'h11000010);
    push(0, 32'h12000000);
    push(0, 32'h11000020);
    push(0, 32'h12000000);
    repeat (20) tick();
    chk("t2_left", 64'(q0.size()), 64'd2);
    chk("t2_ts", tsd0, 64'h10);
    rdy0 = 1;
    repeat (8) tick();
    push(0, 32'h12000001);
    push(0, 32'h11000002);
    push(0, 32'h12000003);
    wait_valid(0, 10);
    chk("t3_ts", tsd0, 64'h0000_0000_0300_0002);
    tick();
    bus_read(16'd3);
    chk("t3_seq_cnt", 64'(bdo0), 64'h01);
    pulses = npulse0;
    push(0, 32'h11000005);
    push(0, 32'h51000000);
    push(0, 32'h12000006);
    wait_valid(0, 10);
    chk("t4_ts", tsd0, 64'h0000_0000_0600_0005);
    tick();
    bus_read(16'd4);
    chk("t4_foreign_cnt", 64'(bdo0), 64'h01);
    chk("t4_pulses", 64'(npulse0 - pulses), 64'd1);
    bus_write(16'd0, 8'h00);
    bus_write(16'd2, 8'h03);
    push(0, 32'h11000100);
    push(0, 32'h12000000);
    wait_valid(0, 10);
    chk("t5_ts_first", tsd0, 64'h100);
    tick();
    push(0, 32'h110000FF);
    push(0, 32'h12000000);
    wait_valid(0, 10);
    chk("t5_ts_second", tsd0, 64'hFF);
    tick();
    bus_read(16'd5);
    chk("t5_mono_cnt", 64'(bdo0), 64'h01);
    for (int n = 0; n < 300; n++) push(0, 32'h15000000);
    repeat (310) tick();
    bus_read(16'd3);
    chk("t5_seq_saturated", 64'(bdo0), 64'hFF);
    bus_write(16'd2, 8'h01);
    rdy1 = 0;
    push(1, 32'h51000000);
    push(1, 32'h11000001);
    push(1, 32'h12000002);
    push(1, 32'h1300BEEF);
    wait_valid(1, 10);
    chk("t6_top", 64'(tsd1[63:48]), 64'hBEEF);
    chk("t6_ts", tsd1, 64'hBEEF_0000_0200_0001);
    bus_write(16'd0, 8'h00);
    chk("t6_valid_dropped", 64'(tv1), 64'h0);
    bus_read(16'd4);
    chk("t6_foreign_cleared", 64'(bdo1), 64'h00);
    bus_read(16'd3);
    chk("t6_seq_cleared", 64'(bdo0), 64'h00);
    rdy1 = 1;
    bus_write(16'd2, 8'h01);
    for (int c = 0; c < 3000; c++) begin
      int r;
      if ($urandom % 2 == 0 && q0.size() < 8) push(0, rnd_word(0));
      if ($urandom % 2 == 0 && q1.size() < 8) push(1, rnd_word(1));
      rdy0 = ($urandom % 4 != 0);
      rdy1 = ($urandom % 4 != 0);
      r = $urandom % 200;
      if (r < 8) bus_read(16'($urandom % 10));
      else if (r < 10) bus_write(16'd2, 8'($urandom % 4) | 8'(($urandom % 4 != 0) ? 1 : 0));
      else if (r == 10) begin
        bus_write(16'd0, 8'h00);
        bus_write(16'd2, 8'($urandom % 4) | 8'h01);
      end else tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
